// File: rtl/bcd_entry_pkg.sv
// Shared constants and types for the BCD entry block.
package bcd_entry_pkg;

   localparam int NDIGITS = 6;
   localparam int VAL_W = 20;
   localparam int unsigned DEF_MAX_VAL = 999999;

   typedef enum logic [1:0] {
      EDIT = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_entry_if.sv
// Link between the entry controller and the serial BCD-to-binary converter.
interface bcd_entry_if;
   import bcd_entry_pkg::*;

   logic                   start;
   logic [NDIGITS*4-1:0]   digits;
   logic                   done;
   logic [VAL_W-1:0]       value;

   modport master (output start, output digits, input done, input value);
   modport slave  (input start, input digits, output done, output value);
endinterface

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter: one digit per cycle, most significant first.
// A start pulse clears the accumulator; done is high during the final
// accumulate cycle, so value holds the result from the next cycle onward.
module bcd_to_bin_serial
   import bcd_entry_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   bcd_entry_if.slave  conv
);

   logic             running_q, running_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [VAL_W-1:0] acc_q, acc_d;
   logic [3:0]       digit;

   // Pick the digit addressed by the counter, highest position first.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      digit = 4'd0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (int'(cnt_q) == NDIGITS - 1 - i) digit = conv.digits[i*4 +: 4];
      end
   end

   // Accumulate acc*10 + digit, with *10 built from two shifts.
   always_comb begin
      running_d = running_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      if (conv.start) begin
         running_d = 1'b1;
         cnt_d     = 3'd0;
         acc_d     = '0;
      end else if (running_q) begin
         acc_d = (acc_q << 3) + (acc_q << 1) + VAL_W'(digit);
         cnt_d = cnt_q + 3'd1;
         if (cnt_q == 3'(NDIGITS - 1)) running_d = 1'b0;
      end
   end

   // Converter registers.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rstn) begin
         running_q <= 1'b0;
         cnt_q     <= 3'd0;
         acc_q     <= '0;
      end else begin
         running_q <= running_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
      end
   end

   assign conv.done  = running_q && (cnt_q == 3'(NDIGITS - 1));
   assign conv.value = acc_q;

endmodule

// File: rtl/bcd_entry.sv
// Six-digit BCD keypad entry with serial conversion and valid/ready output.
// Optional cursor blinking is enabled with the macro BCD_ENTRY_BLINK_EN.
module bcd_entry
   import bcd_entry_pkg::*;
#(
   parameter int unsigned MAX_VAL      = DEF_MAX_VAL,
   parameter int unsigned BLINK_CYCLES = 25_000_000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [3:0]            key_pulse_n,
   input  logic                  ready_i,
   output logic [NDIGITS*4-1:0]  digits_o,
   output logic [NDIGITS-1:0]    cursor_o,
   output logic [NDIGITS-1:0]    blank_o,
   output logic [VAL_W-1:0]      value_o,
   output logic                  value_valid_o,
   output logic                  range_err_o,
   output logic                  busy_o
);

   state_e                 state_q, state_d;
   logic [NDIGITS*4-1:0]   digits_q, digits_d;
   logic [NDIGITS-1:0]     cursor_q, cursor_d;
   logic [3:0]             key;

   bcd_entry_if conv_if ();

   bcd_to_bin_serial u_conv (
      .clk  (clk),
      .rstn (rstn),
      .conv (conv_if)
   );

   assign key            = ~key_pulse_n;
   assign conv_if.digits = digits_q;

   // Next state, key handling (priority clear > commit > left > increment).
   always_comb begin
      state_d       = state_q;
      digits_d      = digits_q;
      cursor_d      = cursor_q;
      conv_if.start = 1'b0;
      unique case (state_q)
         EDIT: begin
            if (key[2]) begin
               digits_d = '0;
               cursor_d = NDIGITS'(1);
            end else if (key[3]) begin
               conv_if.start = 1'b1;
               state_d       = CONV;
            end else if (key[1]) begin
               cursor_d = {cursor_q[NDIGITS-2:0], cursor_q[NDIGITS-1]};
            end else if (key[0]) begin
               for (int i = 0; i < NDIGITS; i++) begin
                  if (cursor_q[i]) begin
                     digits_d[i*4 +: 4] = (digits_q[i*4 +: 4] == 4'd9) ? 4'd0
                                                                       : digits_q[i*4 +: 4] + 4'd1;
                  end
               end
            end
         end
         CONV: if (conv_if.done) state_d = HOLD;
         HOLD: if (ready_i) state_d = EDIT;
         default: state_d = EDIT;
      endcase
   end

   // Controller registers; reset also aborts any conversion in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= EDIT;
         digits_q <= '0;
         cursor_q <= NDIGITS'(1);
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         cursor_q <= cursor_d;
      end
   end

   assign digits_o      = digits_q;
   assign cursor_o      = cursor_q;
   assign busy_o        = (state_q != EDIT);
   assign value_valid_o = (state_q == HOLD);
   assign value_o       = conv_if.value;
   assign range_err_o   = (conv_if.value > VAL_W'(MAX_VAL));

`ifdef BCD_ENTRY_BLINK_EN
   localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_phase_q;

   // Half-period counter; the blink phase flips each time it wraps.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
   end

   assign blank_o = (state_q == EDIT && blink_phase_q) ? cursor_q : '0;
`else
   logic blink_unused;
   assign blink_unused = (BLINK_CYCLES == 0);
   assign blank_o      = '0;
`endif

endmodule
